// File: rtl/shift_engine_pkg.sv
// Shared types for the shift engine: op codes and FSM states.
// Also holds small op-classification helpers used by the top.
package shift_engine_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_LOAD = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_ASR  = 3'd6,
    OP_RSV  = 3'd7
  } op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(op_t o);
    return (o == OP_SHL) || (o == OP_SHR) ||
           (o == OP_ROL) || (o == OP_ROR) ||
           (o == OP_ASR);
  endfunction

  function automatic logic is_left(op_t o);
    return (o == OP_SHL) || (o == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_engine_step.sv
// One combinational shift step: (op, data, ser_in) -> nxt.
// Ports: op, data[WIDTH], ser_in in; nxt[WIDTH] out.
module shift_engine_step
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = data;
    case (op)
      OP_SHL: nxt = {data[WIDTH-2:0], ser_in};
      OP_SHR: nxt = {ser_in, data[WIDTH-1:1]};
      OP_ROL: nxt = {data[WIDTH-2:0], data[WIDTH-1]};
      OP_ROR: nxt = {data[0], data[WIDTH-1:1]};
      OP_ASR: nxt = {data[WIDTH-1], data[WIDTH-1:1]};
      default: nxt = data;
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// Multi-step shift register engine with start/busy/done handshake.
// Ports: clk, rstn, clr, op, start, amount, par_in, ser_in in;
//        par_out, ser_out, busy, done out.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  op_t              op,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  op_t              op_q, op_n;
  logic             left, left_n;
  logic [WIDTH-1:0] data, data_n;
  logic             done_n;
  logic [WIDTH-1:0] step_data;
  logic [CNT_W-1:0] sat_amt;

  localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  shift_engine_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op    (op_q),
    .data  (data),
    .ser_in(ser_in),
    .nxt   (step_data)
  );

  assign sat_amt = (amount > MAX_AMT) ? MAX_AMT : amount;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_HOLD;
      left  <= 1'b0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      left  <= left_n;
      data  <= data_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    left_n  = left;
    data_n  = data;
    done_n  = 1'b0;
    if (clr) begin
      // abort silently: no done pulse
      state_n = ST_IDLE;
      cnt_n   = '0;
      data_n  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_LOAD) begin
              data_n = par_in;
              done_n = 1'b1;
            end else if (!is_shift(op) ||
                         amount == '0) begin
              done_n = 1'b1;
            end else begin
              state_n = ST_SHIFT;
              cnt_n   = sat_amt;
              op_n    = op;
              left_n  = is_left(op);
            end
          end
        end
        ST_SHIFT: begin
          data_n = step_data;
          cnt_n  = cnt - ONE;
          if (cnt == ONE) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign par_out = data;
  assign busy    = (state == ST_SHIFT);
  assign ser_out = left ? data[WIDTH-1] : data[0];

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine (WIDTH=8).
// Scoreboard of final results popped on each done pulse.
module tb_shift_engine;
  import shift_engine_pkg::*;

  logic       clk;
  logic       rstn;
  logic       clr;
  op_t        op;
  logic       start;
  logic [3:0] amount;
  logic [7:0] par_in;
  logic       ser_in;
  logic [7:0] par_out;
  logic       ser_out;
  logic       busy;
  logic       done;

  int n_run;
  int n_fail;
  logic [7:0] mdl;
  logic [7:0] exp_q[$];

  shift_engine #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (clr),
    .op     (op),
    .start  (start),
    .amount (amount),
    .par_in (par_in),
    .ser_in (ser_in),
    .par_out(par_out),
    .ser_out(ser_out),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mstep(op_t o,
                                       logic [7:0] d,
                                       logic s);
    logic [7:0] sv;
    sv = {7'd0, s};
    case (o)
      OP_SHL: return (d << 1) | sv;
      OP_SHR: return (d >> 1) | (sv << 7);
      OP_ROL: return (d << 1) | (d >> 7);
      OP_ROR: return (d >> 1) | (d << 7);
      OP_ASR: return 8'($signed(d) >>> 1);
      default: return d;
    endcase
  endfunction

  function automatic logic m_shift(op_t o);
    return o inside {OP_SHL, OP_SHR, OP_ROL,
                     OP_ROR, OP_ASR};
  endfunction

  always @(negedge clk) begin
    if (rstn && done) begin
      if (exp_q.size() == 0)
        chk("spurious_done", 1, 0);
      else
        chk("result", par_out, exp_q.pop_front());
    end
  end

  task automatic run_op(input op_t o,
                        input logic [3:0] amt,
                        input logic [7:0] pin,
                        input logic sin,
                        input logic inject);
    int steps;
    int cycles;
    steps = 0;
    if (m_shift(o) && amt != 0)
      steps = (amt > 8) ? 8 : int'(amt);
    if (o == OP_LOAD)
      mdl = pin;
    for (int i = 0; i < steps; i++)
      mdl = mstep(o, mdl, sin);
    @(posedge clk); #1;
    op = o; amount = amt; par_in = pin;
    ser_in = sin; start = 1'b1;
    exp_q.push_back(mdl);
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 64) begin
      if (inject && cycles == 1) begin
        start = 1'b1; op = OP_LOAD; par_in = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    if (cycles >= 64) chk("timeout", 1, 0);
    chk("busy_cycles", cycles, steps);
    chk("done_set", done, 1);
    @(posedge clk); #1;
    chk("done_clr", done, 0);
  endtask

  initial begin
    logic [7:0] shl_tab [3];
    n_run = 0; n_fail = 0; mdl = 8'h00;
    rstn = 1'b0; clr = 1'b0; op = OP_HOLD;
    start = 1'b0; amount = '0; par_in = '0;
    ser_in = 1'b0;
    shl_tab[0] = 8'h31;
    shl_tab[1] = 8'h63;
    shl_tab[2] = 8'hC7;
    #12;
    chk("rst_par", par_out, 8'h00);
    chk("rst_ser", ser_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_par", par_out, 8'h00);
    chk("idle_busy", busy, 0);

    run_op(OP_LOAD, 4'd0, 8'h98, 1'b0, 1'b0);
    @(posedge clk); #1;
    op = OP_SHL; amount = 4'd3; ser_in = 1'b1;
    start = 1'b1;
    mdl = 8'hC7;
    exp_q.push_back(mdl);
    @(posedge clk); #1;
    start = 1'b0;
    chk("shl_accept_par", par_out, 8'h98);
    chk("shl_accept_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("shl_step", par_out, shl_tab[i]);
      chk("shl_busy", busy, (i < 2) ? 1 : 0);
    end
    chk("shl_done", done, 1);
    chk("shl_ser_out", ser_out, 1);
    @(posedge clk); #1;
    chk("shl_done_clr", done, 0);

    run_op(OP_LOAD, 4'd0, 8'h98, 1'b0, 1'b0);
    run_op(OP_ASR, 4'd1, 8'h00, 1'b0, 1'b0);
    chk("asr1", par_out, 8'hCC);
    run_op(OP_ASR, 4'd1, 8'h00, 1'b1, 1'b0);
    chk("asr2", par_out, 8'hE6);
    run_op(OP_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0);
    run_op(OP_ROR, 4'd8, 8'h00, 1'b1, 1'b0);
    run_op(OP_ROL, 4'd3, 8'h00, 1'b0, 1'b0);
    chk("rol_ser_out", ser_out, mdl[7]);
    run_op(OP_SHR, 4'd0, 8'h11, 1'b1, 1'b0);
    run_op(OP_HOLD, 4'd5, 8'h22, 1'b1, 1'b0);
    run_op(OP_RSV, 4'd5, 8'h33, 1'b1, 1'b0);
    run_op(OP_SHR, 4'd15, 8'h00, 1'b1, 1'b0);
    chk("sat_par", par_out, 8'hFF);
    run_op(OP_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0);
    run_op(OP_SHR, 4'd2, 8'h00, 1'b0, 1'b0);
    chk("shr_ser_out", ser_out, mdl[0]);
    run_op(OP_LOAD, 4'd0, 8'h81, 1'b0, 1'b0);
    run_op(OP_SHR, 4'd4, 8'h00, 1'b0, 1'b1);

    run_op(OP_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0);
    @(posedge clk); #1;
    op = OP_SHR; amount = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_par", par_out, 8'h00);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_ser", ser_out, 0);
    mdl = 8'h00;
    @(negedge clk); rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_after_busy", busy, 0);
    run_op(OP_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0);

    @(posedge clk); #1;
    op = OP_SHR; amount = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_mid_par", par_out, 8'h00);
    chk("clr_mid_busy", busy, 0);
    mdl = 8'h00;
    repeat (8) @(posedge clk);
    #1;

    run_op(OP_LOAD, 4'd0, 8'h77, 1'b0, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1; start = 1'b1;
    op = OP_LOAD; par_in = 8'hAA;
    @(posedge clk); #1;
    clr = 1'b0; start = 1'b0;
    chk("clr_vs_start", par_out, 8'h00);
    mdl = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_vs_start_busy", busy, 0);
    run_op(OP_LOAD, 4'd0, 8'h0F, 1'b0, 1'b0);
    run_op(OP_SHL, 4'd2, 8'h00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
